// File: rtl/shift_cmd_queue_pkg.sv
// Shared types for the shift command queue.
// One queued command is exactly what the barrel shifter consumes.
package shift_cmd_queue_pkg;

  localparam int CMD_WIDTH = 8;
  localparam int CMD_AMT_W = $clog2(CMD_WIDTH);

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  typedef enum logic {
    SEL_LOGICAL = 1'b0,
    SEL_ARITH   = 1'b1
  } sel_e;

  typedef struct packed {
    logic [CMD_WIDTH-1:0] data;
    logic [CMD_AMT_W-1:0] amount;
    dir_e                 direction;
    sel_e                 selector;
  } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// Storage and pointer logic for queued shift commands.
// Pointers wrap naturally because DEPTH is a power of two.
module shift_cmd_fifo
  import shift_cmd_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  shift_cmd_t    i_cmd,
  output shift_cmd_t    o_head,
  output logic [CW-1:0] o_count
);

  shift_cmd_t          r_mem [DEPTH];
  logic       [PW-1:0] r_wptr;
  logic       [PW-1:0] r_rptr;
  logic       [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush)
      r_mem[r_wptr] <= i_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push)
        r_wptr <= r_wptr + 1'b1;
      if (i_pop)
        r_rptr <= r_rptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/shift_cmd_queue.sv
// FWFT command queue feeding a barrel shifter.
// Adds handshake decode, flush and zero-masking of an empty head.
module shift_cmd_queue
  import shift_cmd_queue_pkg::*;
#(
  parameter int WIDTH = CMD_WIDTH,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(WIDTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_shift_amount,
  input  logic             in_shift_direction,
  input  logic             in_selector,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_in,
  output logic [AW-1:0]    shift_amount,
  output logic             shift_direction,
  output logic             selector,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  shift_cmd_t w_cmd;
  shift_cmd_t w_head;
  shift_cmd_t w_head_m;
  logic       w_push;
  logic       w_pop;

  assign in_ready  = (count != FULL) && !flush;
  assign out_valid = (count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready && !flush;

  always_comb begin
    w_cmd           = '0;
    w_cmd.data      = in_data;
    w_cmd.amount    = in_shift_amount;
    w_cmd.direction = dir_e'(in_shift_direction);
    w_cmd.selector  = sel_e'(in_selector);
  end

  shift_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_cmd   (w_cmd),
    .o_head  (w_head),
    .o_count (count)
  );

  // Stale storage never leaks to the shifter.
  assign w_head_m        = out_valid ? w_head : '0;
  assign data_in         = w_head_m.data;
  assign shift_amount    = w_head_m.amount;
  assign shift_direction = w_head_m.direction;
  assign selector        = w_head_m.selector;

endmodule

// File: doc/shift_cmd_queue.md
SHIFT_CMD_QUEUE -- requirements
Module: shift_cmd_queue

Interface
REQ-001 Parameter WIDTH, default 8: data width of each shift command; identical to the downstream barrel shifter's WIDTH.
REQ-002 Parameter DEPTH, default 4: number of queued commands; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream presents a shift command.
REQ-006 in_ready  output  1  queue accepts a command this cycle.
REQ-007 in_data  input  WIDTH  operand to be shifted.
REQ-008 in_shift_amount  input  $clog2(WIDTH)  shift distance.
REQ-009 in_shift_direction  input  1  0 right shift, 1 left shift.
REQ-010 in_selector  input  1  0 logical shift, 1 arithmetic shift (right shifts only).
REQ-011 flush  input  1  synchronous discard of all queued commands.
REQ-012 out_valid  output  1  head command presented to the shifter.
REQ-013 out_ready  input  1  shifter side consumes the head command.
REQ-014 data_in, shift_amount, shift_direction, selector  output  WIDTH, $clog2(WIDTH), 1, 1  head command fields, wired straight to the barrel shifter operand ports.
REQ-015 count  output  $clog2(DEPTH+1)  number of commands held.

Function
REQ-016 Push SHALL occur on a rising edge when in_valid && in_ready; the four input fields are stored as one entry at the write pointer.
REQ-017 Pop SHALL occur on a rising edge when out_valid && out_ready; the read pointer advances.
REQ-018 in_ready SHALL equal (count != DEPTH) && !flush, decoded combinationally from registered state only, never from in_valid or out_ready.
REQ-019 out_valid SHALL equal (count != 0), from registered state only.
REQ-020 Queue SHALL be first-word-fall-through: a command pushed at edge N SHALL appear on the head outputs with out_valid=1 after edge N, with no further edge needed.
REQ-021 Head outputs SHALL be driven to all-zero whenever out_valid=0.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-023 When full, a pop and an attempted push in the same cycle SHALL complete only the pop, because in_ready=0; count drops to DEPTH-1.
REQ-024 When empty, out_ready has no effect; a push in that cycle raises count to 1.
REQ-025 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no lost or duplicated entry.
REQ-026 Flush SHALL take priority over push and pop: pointers and count go to 0 at the next edge, and no command is accepted or consumed in that cycle.
REQ-027 count SHALL never exceed DEPTH or fall below 0 under any input sequence.
REQ-028 Stored fields SHALL be passed through unmodified; the block performs no shift arithmetic.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately clear count and both pointers.
REQ-030 Outputs during and after reset: out_valid=0, in_ready=1, count=0, head outputs all zero.
REQ-031 Storage array need not be reset; REQ-021 masks its contents.
REQ-032 Reset asserted mid-operation SHALL discard all queued commands; the first push after release is the next head.

Structure
REQ-033 A shared package SHALL hold a packed struct typedef for a shift command (data, amount, direction, selector), parameterised through WIDTH-dependent localparams, plus the direction and selector encoding constants.
REQ-034 Storage and pointer logic SHALL be one sub-module, shift_cmd_fifo, holding entries of the package struct type; shift_cmd_queue adds the handshake decode, flush, and output masking.

Verification
REQ-035 After reset, push {A5h, amount 3, dir 0, sel 1} with out_ready=0 -> next cycle out_valid=1, data_in=A5h, shift_amount=3, shift_direction=0, selector=1, count=1.
REQ-036 Push 5 commands back-to-back with out_ready=0 and DEPTH=4 -> in_ready=0 after the 4th push, 5th not accepted, count=4.
REQ-037 At full, assert in_valid and out_ready together -> only the pop completes, count=3, next head is the 2nd command.
REQ-038 Stream 10 commands with random out_ready -> output order matches input order across pointer wrap, and count never exceeds 4.
REQ-039 At count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, head outputs 0, nothing accepted.
REQ-040 At count=2, drive rst_n low between clock edges -> out_valid=0 and count=0 at once; after release, first push becomes the head.
